uart_tx_arb: RTL and testbench

- Round-robin, packet-locked arbiter that shares the single uart_tx transmitter between NREQ byte-stream requesters.
- Sits between requester FIFOs/engines and the tx core. Accepts bytes on valid/ready, issues one tx_start per byte and tracks tx_busy to sequence frames.
- Inserts a programmable idle gap after each packet.
- Releases a stalled packet owner after a timeout.

---
 rtl/uart_tx_arb_pkg.sv | 23 ++
 rtl/uart_tx_arb_rr_pick.sv | 31 +++
 rtl/uart_tx_arb.sv | 135 +++++++++++++
 tb/tb_uart_tx_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter and its picker.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_GAP     = 3'd5
  } arb_state_e;

  // Ceiling log2, never below 1 so a single-value range still gets one bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [31:0] idx;

  // Scan NREQ positions starting at ptr; ptr is always below NREQ so one subtract wraps
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx[IDW-1:0]]) begin
        any    = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter sharing one uart_tx core between NREQ byte streams.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned GAP_CYC = 16,
  parameter  int unsigned LOCK_TO = 1024,
  localparam int unsigned IDW     = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              owner_vld,
  output logic [IDW-1:0]    owner_id,
  output logic              to_evt
);

  localparam int unsigned GW = clog2(GAP_CYC);
  localparam int unsigned LW = clog2(LOCK_TO);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [LW-1:0] TO_LAST  = LW'((LOCK_TO > 0) ? LOCK_TO - 1 : 0);

  arb_state_e      state_q;
  logic [IDW-1:0]  owner_q;
  logic            owner_vld_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [7:0]      data_q;
  logic            last_q;
  logic [GW-1:0]   gap_q;
  logic [LW-1:0]   to_cnt_q;
  logic            to_evt_q;

  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic [IDW-1:0]  nxt_ptr_d;
  logic            own_vld;
  logic [7:0]      own_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_vld),
    .ptr    (rr_ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign nxt_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign own_vld   = req_vld[owner_q];
  assign own_data  = req_data[{owner_q, 3'b000} +: 8];

  // req_rdy and tx_start are decoded from state so handshake and launch meet their one-cycle latencies
  assign req_rdy   = (state_q == ST_LOAD) ? (req_vld & (NREQ'(1) << owner_q)) : '0;
  assign tx_start  = (state_q == ST_START) && !tx_busy;
  assign tx_data   = data_q;
  assign owner_vld = owner_vld_q;
  assign owner_id  = owner_q;
  assign to_evt    = to_evt_q;

  // Arbitration FSM: grant, byte handshake, frame sequencing, post-packet gap and lock timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      rr_ptr_q    <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      gap_q       <= '0;
      to_cnt_q    <= '0;
      to_evt_q    <= 1'b0;
    end else begin
      to_evt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            owner_q     <= pick_id;
            owner_vld_q <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (own_vld) begin
            data_q   <= own_data;
            last_q   <= req_last[owner_q];
            to_cnt_q <= '0;
            state_q  <= ST_START;
          end else if (LOCK_TO != 0) begin
            if (to_cnt_q == TO_LAST) begin
              to_evt_q    <= 1'b1;
              owner_vld_q <= 1'b0;
              rr_ptr_q    <= nxt_ptr_d;
              to_cnt_q    <= '0;
              state_q     <= ST_IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        ST_START: begin
          if (!tx_busy) state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              owner_vld_q <= 1'b0;
              rr_ptr_q    <= nxt_ptr_d;
              state_q     <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: requester queues, tx core model and a start scoreboard.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 16;
  localparam int unsigned LTO  = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        owner_vld;
  logic [1:0]  owner_id;
  logic        to_evt;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .GAP_CYC(GAP), .LOCK_TO(LTO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_rdy   (req_rdy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .owner_vld (owner_vld),
    .owner_id  (owner_id),
    .to_evt    (to_evt)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          busy_len = 10;
  int          late     = 0;
  int          rem      = 0;
  int          dly      = 0;
  logic        core_rst;
  logic        start_seen;
  logic        frame_active;
  logic        seen_hi;
  logic [7:0]  held;
  logic [3:0]  hs_q;
  logic [3:0]  allowed;
  logic [9:0]  exp_q [$];
  int          start_log [$];
  logic [8:0]  rq [NREQ][$];

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: valid while a byte is queued, pop on a handshake seen in the previous cycle
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_q[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      hs_q[i] = 1'b0;
      if (rq[i].size() > 0) begin
        req_vld[i]         = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_vld[i]         = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // Tx core model: busy rises late+1 cycles after tx_start and stays high busy_len cycles
  always @(posedge clk) begin
    #1;
    if (core_rst) begin
      rem = 0; dly = 0; tx_busy = 1'b0; start_seen = 1'b0;
    end else begin
      if (start_seen) begin
        start_seen = 1'b0; dly = late; rem = busy_len;
      end
      if (rem > 0 && dly > 0) begin
        dly = dly - 1; tx_busy = 1'b0;
      end else if (rem > 0) begin
        tx_busy = 1'b1; rem = rem - 1;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard on tx_start, frame stability, req_rdy ownership
  always @(negedge clk) begin
    if (!rstn) begin
      frame_active = 1'b0; seen_hi = 1'b0; hs_q = '0;
    end else begin
      hs_q    = req_vld & req_rdy;
      allowed = owner_vld ? (4'b0001 << owner_id) : 4'b0000;
      n_assert++;
      if ((req_rdy & ~allowed) !== 4'b0000) begin
        n_fail++; $display("FAIL rdy_owner: req_rdy=%b allowed=%b", req_rdy, allowed);
      end
      if (tx_start) begin
        start_seen = 1'b1;
        start_log.push_back(cyc);
        n_assert++;
        if (frame_active) begin
          n_fail++; $display("FAIL double_start: tx_start=1 required 0 while frame active");
        end
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_start: id=%0d data=%h, none required", owner_id, tx_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({owner_id, tx_data} !== e) begin
            n_fail++; $display("FAIL start_byte: id=%0d data=%h required id=%0d data=%h",
                               owner_id, tx_data, e[9:8], e[7:0]);
          end
        end
        frame_active = 1'b1; seen_hi = 1'b0; held = tx_data;
      end else if (frame_active) begin
        n_assert++;
        if (tx_data !== held) begin
          n_fail++; $display("FAIL data_stable: tx_data=%h required %h", tx_data, held);
        end
        if (tx_busy) seen_hi = 1'b1;
        else if (seen_hi) frame_active = 1'b0;
      end
    end
  end

  task automatic push_pkt(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
    exp_q.push_back({id[1:0], d});
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_starts(input int n, input int bound);
    int k;
    k = 0;
    while (start_log.size() < n && k < bound) begin
      @(negedge clk); #1; k++;
    end
    n_assert++;
    if (start_log.size() < n) begin
      n_fail++; $display("FAIL start_wait: starts=%0d required %0d", start_log.size(), n);
    end
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || frame_active || owner_vld) && k < bound) begin
      @(negedge clk); #1; k++;
    end
    n_assert++;
    if (exp_q.size() != 0 || owner_vld) begin
      n_fail++; $display("FAIL drain: pending=%0d owner_vld=%b required 0/0", exp_q.size(), owner_vld);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; core_rst = 1'b1; tx_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete(); start_log.delete();
    step(2);
  endtask

  task automatic release_rst();
    rstn = 1'b1; core_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++; if (req_rdy !== 4'b0)   begin n_fail++; $display("FAIL rst_rdy: %b required 0", req_rdy); end
    n_assert++; if (tx_start !== 1'b0)  begin n_fail++; $display("FAIL rst_start: %b required 0", tx_start); end
    n_assert++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_data: %h required 00", tx_data); end
    n_assert++; if (owner_vld !== 1'b0) begin n_fail++; $display("FAIL rst_ovld: %b required 0", owner_vld); end
    n_assert++; if (owner_id !== 2'd0)  begin n_fail++; $display("FAIL rst_oid: %0d required 0", owner_id); end
    n_assert++; if (to_evt !== 1'b0)    begin n_fail++; $display("FAIL rst_to: %b required 0", to_evt); end
    release_rst();
    step(3);
  endtask

  task automatic test_single();
    busy_len = 10; late = 0;
    do_reset();
    push_pkt(0, 8'h5A, 1'b0);
    push_pkt(0, 8'hA5, 1'b1);
    release_rst();
    wait_starts(2, 200);
    // within a packet: busy cycles + fall detection + LOAD + START
    n_assert++;
    if (start_log[1] - start_log[0] !== busy_len + 3) begin
      n_fail++; $display("FAIL single_sep: %0d required %0d", start_log[1] - start_log[0], busy_len + 3);
    end
    step(busy_len + 1);
    n_assert++; if (owner_vld !== 1'b1) begin n_fail++; $display("FAIL single_hold: owner_vld=%b required 1", owner_vld); end
    step(1);
    n_assert++; if (owner_vld !== 1'b0) begin n_fail++; $display("FAIL single_rel: owner_vld=%b required 0", owner_vld); end
    push_pkt(1, 8'h3C, 1'b1);
    step(16);
    n_assert++; if (owner_vld !== 1'b0) begin n_fail++; $display("FAIL gap_len: owner_vld=%b required 0", owner_vld); end
    step(1);
    n_assert++;
    if (owner_vld !== 1'b1 || owner_id !== 2'd1) begin
      n_fail++; $display("FAIL gap_grant: vld=%b id=%0d required 1/1", owner_vld, owner_id);
    end
    wait_starts(3, 200);
    drain(300);
  endtask

  task automatic test_rr_order();
    busy_len = 10; late = 0;
    do_reset();
    push_pkt(0, 8'h11, 1'b1);
    push_pkt(1, 8'h22, 1'b1);
    push_pkt(2, 8'h33, 1'b1);
    push_pkt(3, 8'h44, 1'b1);
    push_pkt(0, 8'h55, 1'b1);
    release_rst();
    wait_starts(5, 600);
    for (int k = 1; k < 5 && k < start_log.size(); k++) begin
      // frame (busy + fall detection) + gap + IDLE/LOAD/START
      n_assert++;
      if (start_log[k] - start_log[k-1] !== busy_len + 1 + GAP + 3) begin
        n_fail++; $display("FAIL rr_sep%0d: %0d required %0d", k, start_log[k] - start_log[k-1], busy_len + 1 + GAP + 3);
      end
    end
    drain(300);
  endtask

  task automatic test_lock();
    int k;
    int rdy2_hits;
    busy_len = 10; late = 0;
    do_reset();
    push_pkt(1, 8'h61, 1'b0);
    push_pkt(1, 8'h62, 1'b0);
    push_pkt(1, 8'h63, 1'b1);
    push_pkt(2, 8'h70, 1'b1);
    release_rst();
    k = 0; rdy2_hits = 0;
    while (start_log.size() < 3 && k < 300) begin
      @(negedge clk); #1; k++;
      if (req_rdy[2]) rdy2_hits++;
    end
    n_assert++;
    if (rdy2_hits != 0 || start_log.size() < 3) begin
      n_fail++; $display("FAIL lock_rdy2: hits=%0d starts=%0d required 0/3", rdy2_hits, start_log.size());
    end
    wait_starts(4, 300);
    drain(300);
  endtask

  task automatic test_timeout();
    busy_len = 10; late = 0;
    do_reset();
    push_pkt(3, 8'h33, 1'b0);
    release_rst();
    wait_starts(1, 100);
    push_pkt(0, 8'h0F, 1'b1);
    // LOAD is re-entered busy_len+2 cycles after the start; release 8 cycles later
    step(busy_len + 9);
    n_assert++;
    if (to_evt !== 1'b0 || owner_vld !== 1'b1) begin
      n_fail++; $display("FAIL to_early: to_evt=%b owner_vld=%b required 0/1", to_evt, owner_vld);
    end
    step(1);
    n_assert++;
    if (to_evt !== 1'b1 || owner_vld !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: to_evt=%b owner_vld=%b required 1/0", to_evt, owner_vld);
    end
    step(1);
    n_assert++;
    if (to_evt !== 1'b0 || owner_vld !== 1'b1 || owner_id !== 2'd0) begin
      n_fail++; $display("FAIL to_regrant: to_evt=%b vld=%b id=%0d required 0/1/0", to_evt, owner_vld, owner_id);
    end
    wait_starts(2, 100);
    drain(300);
  endtask

  task automatic test_slow_core();
    busy_len = 10; late = 3;
    do_reset();
    push_pkt(2, 8'h81, 1'b0);
    push_pkt(2, 8'h82, 1'b1);
    release_rst();
    wait_starts(1, 100);
    for (int k = 0; k < 3; k++) begin
      step(1);
      n_assert++;
      if (tx_start !== 1'b0 || tx_data !== 8'h81) begin
        n_fail++; $display("FAIL slow_hold%0d: start=%b data=%h required 0/81", k, tx_start, tx_data);
      end
    end
    wait_starts(2, 200);
    n_assert++;
    if (start_log[1] - start_log[0] !== late + busy_len + 3) begin
      n_fail++; $display("FAIL slow_sep: %0d required %0d", start_log[1] - start_log[0], late + busy_len + 3);
    end
    drain(300);
    late = 0;
  endtask

  task automatic test_reset_mid();
    busy_len = 20; late = 0;
    do_reset();
    push_pkt(1, 8'h99, 1'b1);
    release_rst();
    wait_starts(1, 100);
    step(5);
    rstn = 1'b0;
    #1;
    n_assert++;
    if (owner_vld !== 1'b0 || owner_id !== 2'd0 || tx_data !== 8'h00 ||
        req_rdy !== 4'b0 || tx_start !== 1'b0 || to_evt !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: vld=%b id=%0d data=%h rdy=%b start=%b to=%b required all 0",
                         owner_vld, owner_id, tx_data, req_rdy, tx_start, to_evt);
    end
    core_rst = 1'b1; tx_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete(); start_log.delete();
    push_pkt(2, 8'h2C, 1'b1);
    push_pkt(3, 8'hC3, 1'b1);
    step(2);
    release_rst();
    wait_starts(2, 300);
    drain(300);
    busy_len = 10;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; core_rst = 1'b1; tx_busy = 1'b0;
    req_vld = '0; req_data = '0; req_last = '0;
    start_seen = 1'b0; frame_active = 1'b0; seen_hi = 1'b0; held = '0; hs_q = '0;
    test_reset();
    test_single();
    test_rr_order();
    test_lock();
    test_timeout();
    test_slow_core();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
